ccip_c0_rd_arbiter: RTL and testbench
=====================================

// Module: ccip_c0_rd_arbiter
// PURPOSE
//  Shares the CCI-P c0 (read-request) Tx channel of one host_ccip port among N_REQ AFU-internal read
//  engines. Round-robin arbitration, per-requester outstanding-read credits, honours c0TxAlmFull.
//  Tags each request's mdata with the requester index; steers c0 read responses back by that tag.
//  Sits between hello-world-class engines and host_ccip, inside ofs_plat_afu, in the host_ccip.clk domain.
// PARAMETERS
//  N_REQ            4    number of requesters, 1..16
//  ADDR_W           42   line-address width
//  MAX_OUTSTANDING  64   per-requester in-flight read limit, 1..255
// PORTS
//  clk            in   1             host_ccip.clk
//  reset_n        in   1             asynchronous, active-low
//  req_valid      in   N_REQ         requester i has a read pending
//  req_addr       in   N_REQ*ADDR_W  line address, slice i for requester i
//  req_ready      out  N_REQ         one-hot; request i accepted this cycle when valid&ready
//  c0_tx_valid    out  1             read request to host
//  c0_tx_addr     out  ADDR_W        address of issued request
//  c0_tx_mdata    out  16            {4'b0, req_idx[3:0], seq[7:0]}
//  c0_tx_alm_full in   1             host almost-full
//  c0_rx_valid    in   1             read response valid (rdValid)
//  c0_rx_mdata    in   16            response mdata
//  c0_rx_data     in   512           response line
//  rsp_valid      out  N_REQ         one-hot response strobe to requester
//  rsp_data       out  512           response line, shared by all requesters
//  err_sticky     out  1             bad tag or credit underflow seen; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0; rr pointer=0; all credit counters=0; seq counters=0.
//  - Eligible(i) = req_valid[i] & (outstanding[i] < MAX_OUTSTANDING). Grant when !c0_tx_alm_full.
//  - Round-robin: search starts at (last_grant+1) mod N_REQ, wraps; pointer updates only on a grant.
//  - req_ready is combinational from eligibility, alm_full and rr pointer; at most one bit set.
//  - Issue latency: accept in cycle T -> c0_tx_valid/addr/mdata registered, high in T+1 for 1 cycle.
//  - Back-to-back grants every cycle allowed while alm_full low; alm_full high blocks new accepts
//    from the same cycle; a request already registered still issues (alm_full permits slack).
//  - seq[i] 8-bit, increments per issue of requester i, wraps 255->0.
//  - outstanding[i]: +1 on accept, -1 on response tagged i; both same cycle -> unchanged.
//    At MAX_OUTSTANDING requester i is skipped; the rr search continues to the next eligible.
//  - Response path: c0_rx_valid at T -> rsp_valid[tag] and rsp_data registered at T+1, 1 cycle.
//    tag >= N_REQ: response dropped, err_sticky=1. Response with outstanding[tag]==0: counter stays 0,
//    rsp still delivered, err_sticky=1.
//  - Reset mid-operation clears credits; responses arriving after reset deassertion take the underflow path.
//  - No stalls on response path; requesters must always accept rsp_valid.
// CONFIGURATION
//  CCIP_C0_RD_ARB_STATS_EN defined: adds out port grant_cnt (N_REQ*32), per-requester 32-bit
//    wrapping count of issued requests, reset to 0; and stall_cnt (32) counting cycles with any
//    req_valid set and alm_full high.
//  Not defined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  Package ccip_rd_arb_pkg: t_req_idx (logic[3:0]), t_seq (logic[7:0]), t_credit (logic[7:0]),
//    MDATA_IDX_LSB=8, MDATA_SEQ_LSB=0, function mdata_pack/mdata_idx.
//  Sub-module ccip_rr_arbiter #(N): eligible vector in, one-hot grant + index out, holds rr pointer,
//    advances on grant_taken; reusable for the c1 write channel.
// TESTING
//  1. N_REQ=4, all req_valid=1, alm_full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3; mdata idx matches,
//     seq 0,0,0,0,1,1,1,1.
//  2. Only req 2 valid, MAX_OUTSTANDING=4, no responses -> exactly 4 issues then req_ready[2]=0;
//     one response tag 2 -> one more issue next cycle.
//  3. alm_full raised mid-burst -> no req_ready after the cycle it rises; deassert -> resumes at
//     next rr index, no request lost or duplicated.
//  4. Accept and response for requester 1 in same cycle at outstanding=3 -> stays 3; rsp_valid=4'b0010 at T+1.
//  5. Response with mdata idx=7 (N_REQ=4) -> no rsp_valid, err_sticky=1 and held until reset.
//  6. Async reset asserted with 10 reads in flight -> outputs 0 immediately; post-reset stale response
//     -> delivered, counter 0, err_sticky=1.

Source files
------------

// File: rtl/ccip_rd_arb_pkg.sv
// ccip_rd_arb_pkg: shared types, mdata field positions and mdata pack/unpack helpers
// for the CCI-P c0 read arbiter.
package ccip_rd_arb_pkg;
  typedef logic [3:0] t_req_idx;
  typedef logic [7:0] t_seq;
  typedef logic [7:0] t_credit;
  localparam int MDATA_IDX_LSB = 8;
  localparam int MDATA_SEQ_LSB = 0;
  function automatic logic [15:0] mdata_pack(t_req_idx idx, t_seq seq);
    logic [15:0] m;
    m = '0;
    m[MDATA_IDX_LSB +: 4] = idx;
    m[MDATA_SEQ_LSB +: 8] = seq;
    return m;
  endfunction
  function automatic t_req_idx mdata_idx(logic [15:0] m);
    return m[MDATA_IDX_LSB +: 4];
  endfunction
endpackage

// File: rtl/ccip_rr_arbiter.sv
// ccip_rr_arbiter: round-robin arbiter, search starts one past the last grant.
//   clk, reset_n (async active-low)
//   eligible    in   N   requesters that may be granted this cycle
//   grant_taken in   1   the current grant was used; advance the pointer
//   grant       out  N   one-hot grant (zero when nothing eligible)
//   grant_idx   out  4   index of the granted requester
module ccip_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] eligible,
  input  logic         grant_taken,
  output logic [N-1:0] grant,
  output logic [3:0]   grant_idx
);
  logic [3:0]   ptr;
  logic [4:0]   j;
  logic [N-1:0] sh;
  logic         found;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = '0;
    sh = '0;
    for (int k = 0; k < N; k++) begin
      j = 5'(ptr) + 5'(k);
      j = (j >= 5'(N)) ? j - 5'(N) : j;
      sh = eligible >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        grant = N'(1) << j;
        grant_idx = j[3:0];
      end
    end
  end
  // ptr holds the next search start, so reset to 0 makes requester 0 first.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (grant_taken) ptr <= (grant_idx == 4'(N - 1)) ? '0 : grant_idx + 4'd1;
endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter: shares the CCI-P c0 read-request channel among N_REQ engines with
// round-robin arbitration, per-requester credits and mdata-tag based response steering.
//   clk, reset_n (async active-low)
//   req_valid/req_addr/req_ready : requester side, request i accepted when valid&ready
//   c0_tx_valid/addr/mdata       : registered request to host, mdata = {4'b0, idx, seq}
//   c0_tx_alm_full               : host almost-full, blocks new accepts in the same cycle
//   c0_rx_valid/mdata/data       : read response from host
//   rsp_valid/rsp_data           : registered one-hot response strobe and shared line
//   err_sticky                   : bad tag or credit underflow seen, cleared only by reset
// Optional CCIP_C0_RD_ARB_STATS_EN adds grant_cnt (per-requester issue count) and stall_cnt.
module ccip_c0_rd_arbiter
  import ccip_rd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 42,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    c0_tx_valid,
  output logic [ADDR_W-1:0]       c0_tx_addr,
  output logic [15:0]             c0_tx_mdata,
  input  logic                    c0_tx_alm_full,
  input  logic                    c0_rx_valid,
  input  logic [15:0]             c0_rx_mdata,
  input  logic [511:0]            c0_rx_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [511:0]            rsp_data,
  output logic                    err_sticky
`ifdef CCIP_C0_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]     grant_cnt,
  output logic [31:0]             stall_cnt
`endif
);
  logic [N_REQ-1:0]    eligible, grant, rsp_hit, dec;
  logic [3:0]          grant_idx, rx_idx;
  t_credit [N_REQ-1:0] credit;
  t_seq [N_REQ-1:0]    seq;
  logic                accept, tag_ok, underflow;
  logic [ADDR_W-1:0]   sel_addr;
  t_seq                sel_seq;
  logic                unused_mdata;
  assign unused_mdata = ^{c0_rx_mdata[15:12], c0_rx_mdata[7:0]};
  assign rx_idx = mdata_idx(c0_rx_mdata);
  assign tag_ok = {1'b0, rx_idx} < 5'(N_REQ);
  assign req_ready = c0_tx_alm_full ? '0 : grant;
  assign accept = |req_ready;
  always_comb begin
    eligible = '0;
    rsp_hit = '0;
    dec = '0;
    underflow = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && credit[i] < t_credit'(MAX_OUTSTANDING);
      rsp_hit[i] = c0_rx_valid && rx_idx == 4'(i);
      dec[i] = rsp_hit[i] && credit[i] != '0;
      underflow = underflow | (rsp_hit[i] && credit[i] == '0);
    end
  end
  always_comb begin
    sel_addr = '0;
    sel_seq = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_addr = req_ready[i] ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr;
      sel_seq = req_ready[i] ? seq[i] : sel_seq;
    end
  end
  ccip_rr_arbiter #(.N(N_REQ)) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .eligible   (eligible),
    .grant_taken(accept),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );
  // An underflowing response is still delivered; only the counter refuses to go negative.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      c0_tx_valid <= 1'b0;
      c0_tx_addr <= '0;
      c0_tx_mdata <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      err_sticky <= 1'b0;
      credit <= '0;
      seq <= '0;
    end else begin
      c0_tx_valid <= accept;
      c0_tx_addr <= sel_addr;
      c0_tx_mdata <= mdata_pack(grant_idx, sel_seq);
      rsp_valid <= rsp_hit;
      rsp_data <= c0_rx_data;
      err_sticky <= err_sticky | (c0_rx_valid && (!tag_ok || underflow));
      for (int i = 0; i < N_REQ; i++) begin
        credit[i] <= credit[i] + t_credit'(req_ready[i]) - t_credit'(dec[i]);
        seq[i] <= seq[i] + t_seq'(req_ready[i]);
      end
    end
`ifdef CCIP_C0_RD_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'(req_ready[i]);
      stall_cnt <= stall_cnt + 32'(|req_valid && c0_tx_alm_full);
    end
`endif
endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// tb_ccip_c0_rd_arbiter: randomized scoreboard bench with a behavioural credit/round-robin model.
module tb_ccip_c0_rd_arbiter;
  localparam int N = 4;
  localparam int AW = 42;
  localparam int MAXO = 4;
  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      req_ready;
  logic              c0_tx_valid;
  logic [AW-1:0]     c0_tx_addr;
  logic [15:0]       c0_tx_mdata;
  logic              c0_tx_alm_full = 1'b0;
  logic              c0_rx_valid = 1'b0;
  logic [15:0]       c0_rx_mdata = '0;
  logic [511:0]      c0_rx_data = '0;
  logic [N-1:0]      rsp_valid;
  logic [511:0]      rsp_data;
  logic              err_sticky;
`ifdef CCIP_C0_RD_ARB_STATS_EN
  logic [N*32-1:0]   grant_cnt;
  logic [31:0]       stall_cnt;
`endif
  always #5 clk = ~clk;
  ccip_c0_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .c0_tx_valid   (c0_tx_valid),
    .c0_tx_addr    (c0_tx_addr),
    .c0_tx_mdata   (c0_tx_mdata),
    .c0_tx_alm_full(c0_tx_alm_full),
    .c0_rx_valid   (c0_rx_valid),
    .c0_rx_mdata   (c0_rx_mdata),
    .c0_rx_data    (c0_rx_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .err_sticky    (err_sticky)
`ifdef CCIP_C0_RD_ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );
  typedef struct {logic [AW-1:0] addr; logic [15:0] mdata;} tx_t;
  typedef struct {logic [N-1:0] vld; logic [511:0] data;} rsp_t;
  tx_t         txq[$];
  rsp_t        rspq[$];
  logic [15:0] inflight[$];
  int compared = 0;
  int mismatched = 0;
  int m_ptr;
  int m_out[N];
  int m_seq[N];
  bit m_err;
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_ptr = 0;
    m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_out[i] = 0;
      m_seq[i] = 0;
    end
  endtask
  // One cycle: drive inputs, check req_ready/err_sticky against the model, predict outputs.
  task automatic step(input logic [N-1:0] rv, input logic alm, input logic rxv, input logic [15:0] rxm);
    int g, j, tag;
    logic [N-1:0] exp_rdy;
    logic [15:0] md;
    @(posedge clk);
    #2;
    req_valid = rv;
    c0_tx_alm_full = alm;
    c0_rx_valid = rxv;
    c0_rx_mdata = rxm;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'({$urandom, $urandom});
    for (int i = 0; i < 16; i++) c0_rx_data[i*32 +: 32] = $urandom;
    #1;
    check("err_sticky", err_sticky, m_err);
    g = -1;
    if (!alm)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && rv[j] && m_out[j] < MAXO) g = j;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      md = {4'd0, 4'(g), 8'(m_seq[g])};
      txq.push_back('{req_addr[g*AW +: AW], md});
      inflight.push_back(md);
      m_seq[g] = (m_seq[g] + 1) % 256;
      m_ptr = (g + 1) % N;
    end
    if (rxv) begin
      tag = (int'(rxm) >> 8) & 15;
      if (tag >= N) m_err = 1'b1;
      else begin
        if (m_out[tag] == 0) m_err = 1'b1;
        else m_out[tag]--;
        rspq.push_back('{N'(1) << tag, c0_rx_data});
      end
    end
    if (g >= 0) m_out[g]++;
  endtask
  function automatic logic [15:0] take();
    int k;
    k = $urandom_range(inflight.size() - 1);
    take = inflight[k];
    inflight.delete(k);
  endfunction
  task automatic drain();
    logic [15:0] m;
    while (inflight.size() > 0) begin
      m = take();
      step('0, 1'b0, 1'b1, m);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    req_valid = '0;
    c0_rx_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_c0_tx_valid", c0_tx_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_req_ready", req_ready, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask
  initial begin
    tx_t e;
    rsp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (c0_tx_valid) begin
        if (txq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx_unexpected: got mdata %0h expected no request", c0_tx_mdata);
        end else begin
          e = txq.pop_front();
          check("c0_tx_addr", c0_tx_addr, e.addr);
          check("c0_tx_mdata", c0_tx_mdata, e.mdata);
        end
      end
      if (rsp_valid != '0) begin
        if (rspq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rsp_unexpected: got rsp_valid %0h expected none", rsp_valid);
        end else begin
          r = rspq.pop_front();
          check("rsp_valid", rsp_valid, r.vld);
          check("rsp_data", rsp_data, r.data);
        end
      end
    end
  end
  initial begin
    logic [15:0] m;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check("init_c0_tx_valid", c0_tx_valid, 1'b0);
    check("init_rsp_valid", rsp_valid, '0);
    check("init_err_sticky", err_sticky, 1'b0);
    check("init_c0_tx_mdata", c0_tx_mdata, 16'h0);
    #19 reset_n = 1'b1;
    repeat (8) step('1, 1'b0, 1'b0, '0);
    drain();
    repeat (6) step(4'b0100, 1'b0, 1'b0, '0);
    m = take();
    step(4'b0100, 1'b0, 1'b1, m);
    repeat (2) step(4'b0100, 1'b0, 1'b0, '0);
    drain();
    repeat (3) step('1, 1'b0, 1'b0, '0);
    repeat (3) step('1, 1'b1, 1'b0, '0);
    repeat (3) step('1, 1'b0, 1'b0, '0);
    drain();
    repeat (3) step(4'b0010, 1'b0, 1'b0, '0);
    m = take();
    step(4'b0010, 1'b0, 1'b1, m);
    repeat (2) step(4'b0000, 1'b0, 1'b0, '0);
    drain();
    step('0, 1'b0, 1'b1, 16'h0700);
    repeat (3) step('0, 1'b0, 1'b0, '0);
    repeat (10) step('1, 1'b0, 1'b0, '0);
    do_reset();
    m = take();
    step('0, 1'b0, 1'b1, m);
    inflight.delete();
    repeat (2) step('0, 1'b0, 1'b0, '0);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (inflight.size() > 0 && $urandom_range(1) == 1) begin
        m = take();
        step(N'($urandom), $urandom_range(9) == 0, 1'b1, m);
      end else if ($urandom_range(49) == 0)
        step(N'($urandom), $urandom_range(9) == 0, 1'b1, {4'd0, 4'($urandom_range(15, 4)), 8'($urandom)});
      else
        step(N'($urandom), $urandom_range(9) == 0, 1'b0, '0);
    end
    drain();
    repeat (3) step('0, 1'b0, 1'b0, '0);
    check("txq_left", 32'(txq.size()), 32'd0);
    check("rspq_left", 32'(rspq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
